// File: rtl/vae_frame_scheduler_pkg.sv
// Shared types and geometry for the VAE frame scheduler: image/cell sizes,
// window placement, the write FSM state type and the sample clamp.
package vae_disp_pkg;

    localparam int IMG_DIM    = 14;
    localparam int IMG_PIXELS = IMG_DIM * IMG_DIM;
    localparam int CELL_PX    = 20;
    localparam int OFS_X      = 180;
    localparam int OFS_Y      = 100;
    localparam int SWAP_LINE  = 480;

    typedef logic [3:0]        pixel_t;
    typedef logic signed [9:0] sample_t;

    typedef enum logic [0:0] {
        FILL      = 1'b0,
        WAIT_SWAP = 1'b1
    } wr_state_e;

    localparam pixel_t     BG_VALUE = 4'hF;
    localparam logic [7:0] LAST_IDX = 8'(IMG_PIXELS - 1);

    // Saturate a signed decoder sample into the 4-bit intensity range.
    function automatic pixel_t clamp_sample(input sample_t s);
        pixel_t p;
        if (s < 10'sd0) begin
            p = 4'h0;
        end else if (s > 10'sd15) begin
            p = 4'hF;
        end else begin
            p = s[3:0];
        end
        return p;
    endfunction

endpackage

// File: rtl/vae_frame_scheduler_if.sv
// Decoder-to-scheduler sample stream: valid/ready handshake with an
// end-of-image marker.
interface vae_frame_scheduler_if;
    import vae_disp_pkg::*;

    logic    in_valid;
    logic    in_ready;
    sample_t in_data;
    logic    in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/vae_frame_scheduler_pix_addr_gen.sv
// Maps the VGA h_cnt/v_cnt position to the image window flag and the cell
// address (column + IMG_DIM*row) by counting crossed cell boundaries.
module vae_pix_addr_gen
    import vae_disp_pkg::*;
(
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    output logic       win,
    output logic [7:0] addr
);

    logic [9:0] dx_s;
    logic [9:0] dy_s;
    logic [3:0] col_s;
    logic [3:0] row_s;

    // Window test and cell column/row counts; both counts saturate at IMG_DIM-1
    // so the address never leaves 0..195 even outside the window.
    always_comb begin
        dx_s  = h_cnt - 10'(OFS_X);
        dy_s  = v_cnt - 10'(OFS_Y);
        win   = (h_cnt > 10'(OFS_X)) && (h_cnt < 10'(OFS_X + IMG_DIM * CELL_PX)) &&
                (v_cnt > 10'(OFS_Y)) && (v_cnt < 10'(OFS_Y + IMG_DIM * CELL_PX));
        col_s = 4'd0;
        row_s = 4'd0;
        for (int k = 1; k < IMG_DIM; k++) begin
            col_s = col_s + {3'd0, (dx_s >= 10'(k * CELL_PX))};
            row_s = row_s + {3'd0, (dy_s >= 10'(k * CELL_PX))};
        end
        // row*14 = row*16 - row*2
        addr  = {4'd0, col_s} + ({row_s, 4'd0} - {3'd0, row_s, 1'b0});
    end

endmodule

// File: rtl/vae_frame_scheduler.sv
// Double-buffered 14x14 pixel store: fills the back bank from the decoder
// stream and swaps banks only at the frame boundary line.
module vae_frame_scheduler
    import vae_disp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    vae_frame_scheduler_if.slave  smp,
    input  logic [9:0]            h_cnt,
    input  logic [9:0]            v_cnt,
    output pixel_t                pix_value,
    output logic                  pix_in_win,
    output logic                  swap_pulse,
    output logic                  front_bank,
    output logic                  frame_err
);

    wr_state_e  state_r;
    wr_state_e  state_next_s;
    logic [7:0] wr_idx_r;
    logic [7:0] wr_idx_next_s;
    logic       front_bank_r;
    logic       swap_pulse_r;
    logic       frame_err_r;
    logic       in_ready_r;
    pixel_t     pix_value_r;
    logic       pix_in_win_r;

    logic       accept_s;
    logic       swap_s;
    logic       err_set_s;
    logic       swap_cond_s;
    pixel_t     wr_pix_s;
    pixel_t     rd_pix_s;
    logic       win_s;
    logic [7:0] addr_s;

    pixel_t     bank0_r [IMG_PIXELS];
    pixel_t     bank1_r [IMG_PIXELS];

    vae_pix_addr_gen u_addr_gen (
        .h_cnt (h_cnt),
        .v_cnt (v_cnt),
        .win   (win_s),
        .addr  (addr_s)
    );

    assign smp.in_ready = in_ready_r;
    assign pix_value    = pix_value_r;
    assign pix_in_win   = pix_in_win_r;
    assign swap_pulse   = swap_pulse_r;
    assign front_bank   = front_bank_r;
    assign frame_err    = frame_err_r;

    assign swap_cond_s  = (v_cnt == 10'(SWAP_LINE)) && (h_cnt == 10'd0);
    assign wr_pix_s     = clamp_sample(smp.in_data);

    // Write FSM next-state, index advance, swap and framing-error decode
    always_comb begin
        state_next_s  = state_r;
        wr_idx_next_s = wr_idx_r;
        swap_s        = 1'b0;
        err_set_s     = 1'b0;
        accept_s      = smp.in_valid && (state_r == FILL);
        case (state_r)
            FILL: begin
                if (accept_s) begin
                    err_set_s = smp.in_last && (wr_idx_r != LAST_IDX);
                    if ((wr_idx_r == LAST_IDX) || smp.in_last) begin
                        state_next_s  = WAIT_SWAP;
                        wr_idx_next_s = 8'd0;
                    end else begin
                        wr_idx_next_s = wr_idx_r + 8'd1;
                    end
                end else begin
                    state_next_s = FILL;
                end
            end
            WAIT_SWAP: begin
                if (swap_cond_s) begin
                    state_next_s = FILL;
                    swap_s       = 1'b1;
                end else begin
                    state_next_s = WAIT_SWAP;
                end
            end
            default: begin
                state_next_s  = FILL;
                wr_idx_next_s = 8'd0;
            end
        endcase
    end

    // State, handshake, bank-select and error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= FILL;
            wr_idx_r     <= 8'd0;
            front_bank_r <= 1'b0;
            swap_pulse_r <= 1'b0;
            frame_err_r  <= 1'b0;
            in_ready_r   <= 1'b1;
        end else begin
            state_r      <= state_next_s;
            wr_idx_r     <= wr_idx_next_s;
            front_bank_r <= front_bank_r ^ swap_s;
            swap_pulse_r <= swap_s;
            frame_err_r  <= frame_err_r | err_set_s;
            in_ready_r   <= (state_next_s == FILL);
        end
    end

    // Back-bank writes; the bank opposite front_bank is the only write target
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IMG_PIXELS; i++) begin
                bank0_r[i] <= 4'h0;
                bank1_r[i] <= 4'h0;
            end
        end else if (accept_s) begin
            if (front_bank_r) begin
                bank0_r[wr_idx_r] <= wr_pix_s;
            end else begin
                bank1_r[wr_idx_r] <= wr_pix_s;
            end
        end else begin
            bank0_r[0] <= bank0_r[0];
        end
    end

    assign rd_pix_s = front_bank_r ? bank1_r[addr_s] : bank0_r[addr_s];

    // One-cycle read pipeline from the front bank
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_value_r  <= BG_VALUE;
            pix_in_win_r <= 1'b0;
        end else begin
            pix_value_r  <= win_s ? rd_pix_s : BG_VALUE;
            pix_in_win_r <= win_s;
        end
    end

endmodule
